// File: rtl/imm_encoder_if.sv
// Request/response bundle for imm_encoder.
// The slave modport is the encoder's view of the bundle; the master modport is the requester's view.
interface imm_encoder_if #(
  parameter int ERR_CNT_W = 16
);
  logic                 in_valid;
  logic                 in_ready;
  logic [1:0]           ImmSrc;
  logic [31:0]          Imm;
  logic [31:0]          BaseInstr;
  logic                 out_valid;
  logic                 out_ready;
  logic [31:0]          Instr;
  logic                 out_err;
  logic [ERR_CNT_W-1:0] err_count;

  modport master (
    output in_valid, ImmSrc, Imm, BaseInstr, out_ready,
    input  in_ready, out_valid, Instr, out_err, err_count
  );

  modport slave (
    input  in_valid, ImmSrc, Imm, BaseInstr, out_ready,
    output in_ready, out_valid, Instr, out_err, err_count
  );
endinterface

// File: rtl/imm_encoder.sv
// Two-stage valid/ready pipeline that merges an I/S/B/J immediate into a base instruction.
// Optional macro IMM_RANGE_CHECK_EN adds the range check, out_err and the saturating err_count.
module imm_encoder #(
  parameter int ERR_CNT_W = 16
) (
  input  logic         clk,
  input  logic         reset,
  imm_encoder_if.slave bus
);

  localparam logic [1:0] FMT_I = 2'b00;
  localparam logic [1:0] FMT_S = 2'b01;
  localparam logic [1:0] FMT_B = 2'b10;
  localparam logic [1:0] FMT_J = 2'b11;

`ifdef IMM_RANGE_CHECK_EN
  localparam int IMM_W = 32;
`else
  localparam int IMM_W = 21;  // encoding never uses Imm bits above 20
`endif

  logic             s1_valid_q, s1_valid_d;
  logic [1:0]       s1_src_q, s1_src_d;
  logic [IMM_W-1:0] s1_imm_q, s1_imm_d;
  logic [31:0]      s1_base_q, s1_base_d;
  logic             s2_valid_q, s2_valid_d;
  logic [31:0]      s2_instr_q, s2_instr_d;
  logic [31:0]      enc_instr;
  logic             out_xfer, s2_load, s1_adv, in_xfer;

  // No transfer in either direction may complete while reset is high.
  assign out_xfer     = s2_valid_q && bus.out_ready && !reset;
  assign s2_load      = !s2_valid_q || out_xfer;
  assign s1_adv       = s1_valid_q && s2_load;
  assign bus.in_ready = !reset && (!s1_valid_q || s2_load);
  assign in_xfer      = bus.in_valid && bus.in_ready;

  always_comb begin
    enc_instr = s1_base_q;
    case (s1_src_q)
      FMT_I: enc_instr[31:20] = s1_imm_q[11:0];
      FMT_S: begin
        enc_instr[31:25] = s1_imm_q[11:5];
        enc_instr[11:7]  = s1_imm_q[4:0];
      end
      FMT_B: begin
        enc_instr[31]    = s1_imm_q[12];
        enc_instr[30:25] = s1_imm_q[10:5];
        enc_instr[11:8]  = s1_imm_q[4:1];
        enc_instr[7]     = s1_imm_q[11];
      end
      default: begin
        enc_instr[31]    = s1_imm_q[20];
        enc_instr[30:21] = s1_imm_q[10:1];
        enc_instr[20]    = s1_imm_q[11];
        enc_instr[19:12] = s1_imm_q[19:12];
      end
    endcase
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_src_d   = s1_src_q;
    s1_imm_d   = s1_imm_q;
    s1_base_d  = s1_base_q;
    s2_valid_d = s2_valid_q;
    s2_instr_d = s2_instr_q;
    if (s1_adv) s1_valid_d = 1'b0;
    if (in_xfer) begin
      s1_valid_d = 1'b1;
      s1_src_d   = bus.ImmSrc;
      s1_imm_d   = bus.Imm[IMM_W-1:0];
      s1_base_d  = bus.BaseInstr;
    end
    if (s2_load) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) s2_instr_d = enc_instr;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s1_src_q   <= '0;
      s1_imm_q   <= '0;
      s1_base_q  <= '0;
      s2_valid_q <= 1'b0;
      s2_instr_q <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_src_q   <= s1_src_d;
      s1_imm_q   <= s1_imm_d;
      s1_base_q  <= s1_base_d;
      s2_valid_q <= s2_valid_d;
      s2_instr_q <= s2_instr_d;
    end
  end

  assign bus.out_valid = s2_valid_q && !reset;
  assign bus.Instr     = reset ? '0 : s2_instr_q;

`ifdef IMM_RANGE_CHECK_EN
  logic                 enc_err;
  logic                 s2_err_q, s2_err_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

  // Representable means every bit above the field's sign bit copies it.
  always_comb begin
    enc_err = 1'b0;
    case (s1_src_q)
      FMT_I, FMT_S: enc_err = !(&s1_imm_q[31:11] || !(|s1_imm_q[31:11]));
      FMT_B:        enc_err = !((&s1_imm_q[31:12] || !(|s1_imm_q[31:12])) && !s1_imm_q[0]);
      default:      enc_err = !((&s1_imm_q[31:20] || !(|s1_imm_q[31:20])) && !s1_imm_q[0]);
    endcase
  end

  always_comb begin
    s2_err_d  = s2_err_q;
    err_cnt_d = err_cnt_q;
    if (s2_load && s1_valid_q) s2_err_d = enc_err;
    if (out_xfer && s2_err_q && !(&err_cnt_q)) err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s2_err_q  <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      s2_err_q  <= s2_err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign bus.out_err   = s2_err_q && !reset;
  assign bus.err_count = reset ? '0 : err_cnt_q;
`else
  assign bus.out_err   = 1'b0;
  assign bus.err_count = '0;
`endif

endmodule

// File: tb/tb_imm_encoder.sv
// Self-checking bench for imm_encoder: directed literal cases plus randomized traffic
// scored against a bit-mapping / signed-range reference model.
module tb_imm_encoder;
  localparam int ECW = 16;
`ifdef IMM_RANGE_CHECK_EN
  localparam logic CHK_EN = 1'b1;
`else
  localparam logic CHK_EN = 1'b0;
`endif

  typedef struct {
    logic [31:0] instr;
    logic        err;
    logic        ok;
    logic [31:0] imm;
    logic [1:0]  src;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  int          mode = 1;  // out_ready: 0 low, 1 high, 2 random
  int          checks = 0;
  int          errors = 0;
  int          out_count = 0;
  int          model_cnt = 0;
  exp_t        exp_q[$];
  logic        prev_stall = 1'b0;
  logic [31:0] prev_instr = '0;
  logic        prev_err = 1'b0;
  logic [1:0]  r_src[4];
  logic [31:0] r_imm[4];
  logic [31:0] r_base[4];

  always #5 clk = ~clk;

  imm_encoder_if #(.ERR_CNT_W(ECW)) bus ();
  imm_encoder #(.ERR_CNT_W(ECW)) dut (.clk(clk), .reset(reset), .bus(bus));

  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      if (mode == 0) bus.out_ready = 1'b0;
      else if (mode == 1) bus.out_ready = 1'b1;
      else bus.out_ready = ($urandom % 3) != 0;
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic in_range(logic [1:0] src, logic [31:0] imm);
    int v;
    v = $signed(imm);
    case (src)
      2'd0, 2'd1: return (v >= -2048) && (v <= 2047);
      2'd2:       return (v >= -4096) && (v <= 4095) && !imm[0];
      default:    return (v >= -1048576) && (v <= 1048575) && !imm[0];
    endcase
  endfunction

  function automatic logic [31:0] model_encode(logic [1:0] src, logic [31:0] imm, logic [31:0] base);
    logic [31:0] r;
    r = base;
    case (src)
      2'd0: for (int k = 0; k < 12; k++) r[20+k] = imm[k];
      2'd1: begin
        for (int k = 0; k < 5; k++)  r[7+k]  = imm[k];
        for (int k = 5; k < 12; k++) r[20+k] = imm[k];
      end
      2'd2: begin
        r[7] = imm[11];
        for (int k = 1; k < 5; k++)  r[7+k]  = imm[k];
        for (int k = 5; k < 11; k++) r[20+k] = imm[k];
        r[31] = imm[12];
      end
      default: begin
        for (int k = 1; k < 11; k++)  r[20+k] = imm[k];
        r[20] = imm[11];
        for (int k = 12; k < 20; k++) r[k] = imm[k];
        r[31] = imm[20];
      end
    endcase
    return r;
  endfunction

  // Immediate extraction as the core's decoder does it.
  function automatic logic [31:0] decode(logic [1:0] src, logic [31:0] i);
    case (src)
      2'd0:    return {{20{i[31]}}, i[31:20]};
      2'd1:    return {{20{i[31]}}, i[31:25], i[11:7]};
      2'd2:    return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      default: return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
    endcase
  endfunction

  function automatic logic [31:0] rand_imm(logic [1:0] src);
    int lim;
    int v;
    lim = (src <= 2'd1) ? 2048 : ((src == 2'd2) ? 4096 : 1048576);
    case ($urandom % 4)
      0: return $urandom;
      1: begin v = int'($urandom_range(2 * lim + 3)) - lim - 2; return 32'(v); end
      2: begin v = int'($urandom_range(64)) - 32; return 32'(v); end
      default: begin v = int'($urandom_range(2 * lim + 3)) - lim - 2; return 32'(v) & ~32'd1; end
    endcase
  endfunction

  task automatic monitor_step();
    exp_t e;
    @(negedge clk);
    if (reset) begin
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_instr", bus.Instr, 32'd0);
      chk("rst_out_err", 32'(bus.out_err), 32'd0);
      chk("rst_err_count", 32'(bus.err_count), 32'd0);
      exp_q.delete();
      model_cnt = 0;
      prev_stall = 1'b0;
    end else begin
      chk("err_count", 32'(bus.err_count), 32'(model_cnt));
      if (prev_stall) begin
        chk("hold_valid", 32'(bus.out_valid), 32'd1);
        chk("hold_instr", bus.Instr, prev_instr);
        chk("hold_err", 32'(bus.out_err), 32'(prev_err));
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          chk("spurious_output", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("instr", bus.Instr, e.instr);
          chk("out_err", 32'(bus.out_err), 32'(e.err));
          if (e.ok) chk("round_trip", decode(e.src, bus.Instr), e.imm);
          if (e.err && model_cnt < (1 << ECW) - 1) model_cnt++;
          out_count++;
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        e.src   = bus.ImmSrc;
        e.imm   = bus.Imm;
        e.ok    = in_range(bus.ImmSrc, bus.Imm);
        e.err   = CHK_EN && !e.ok;
        e.instr = model_encode(bus.ImmSrc, bus.Imm, bus.BaseInstr);
        exp_q.push_back(e);
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_instr = bus.Instr;
      prev_err   = bus.out_err;
    end
  endtask

  task automatic single(input logic [1:0] src, input logic [31:0] imm, input logic [31:0] base,
                        input logic [31:0] exp_instr, input logic exp_err);
    bus.ImmSrc = src; bus.Imm = imm; bus.BaseInstr = base; bus.in_valid = 1'b1;
    @(negedge clk); chk("lat_in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1; bus.in_valid = 1'b0;
    @(negedge clk); chk("lat_cycle1_valid", 32'(bus.out_valid), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("lat_cycle2_valid", 32'(bus.out_valid), 32'd1);
    chk("lit_instr", bus.Instr, exp_instr);
    chk("lit_err", 32'(bus.out_err), 32'(exp_err));
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [1:0] src, input logic [31:0] imm, input logic [31:0] base);
    logic ok;
    ok = 1'b0;
    bus.ImmSrc = src; bus.Imm = imm; bus.BaseInstr = base; bus.in_valid = 1'b1;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (bus.in_ready) begin ok = 1'b1; break; end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    if (!ok) chk("send_timeout", 32'd0, 32'd1);
  endtask

  // Stream r_*[0..n-1]; with stall_cycles > 0, out_ready is released after that many cycles.
  task automatic stream(input int n, input int stall_cycles);
    int idx;
    int cyc;
    idx = 0; cyc = 0;
    bus.ImmSrc = r_src[0]; bus.Imm = r_imm[0]; bus.BaseInstr = r_base[0]; bus.in_valid = 1'b1;
    while (idx < n && cyc < 60) begin
      @(negedge clk);
      if (bus.in_ready) idx++;
      if (stall_cycles > 0 && cyc == stall_cycles - 1) begin
        chk("bp_accepted", 32'(idx), 32'd2);
        chk("bp_in_ready_low", 32'(bus.in_ready), 32'd0);
      end
      @(posedge clk); #1;
      if (stall_cycles > 0 && cyc == stall_cycles - 1) mode = 1;
      if (idx < n) begin
        bus.ImmSrc = r_src[idx]; bus.Imm = r_imm[idx]; bus.BaseInstr = r_base[idx];
      end else bus.in_valid = 1'b0;
      cyc++;
    end
    bus.in_valid = 1'b0;
    chk("stream_sent", 32'(idx), 32'(n));
  endtask

  task automatic wait_drain();
    for (int t = 0; t < 300 && exp_q.size() != 0; t++) @(negedge clk);
    chk("drain_empty", 32'(exp_q.size()), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic run_all();
    int start;
    logic [1:0] s;
    repeat (3) @(posedge clk);
    #1; reset = 1'b0;
    @(negedge clk); chk("in_ready_after_reset", 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;

    single(2'd0, 32'hFFFF_FFFF, 32'h0000_0013, 32'hFFF0_0013, 1'b0);
    single(2'd1, 32'hFFFF_FFFB, 32'h0000_0023, 32'hFE00_0DA3, 1'b0);
    single(2'd2, 32'h0000_0FFE, 32'h0000_0063, 32'h7E00_0FE3, 1'b0);
    single(2'd2, 32'h0000_0FFF, 32'h0000_0063, 32'h7E00_0FE3, CHK_EN);
    @(negedge clk); chk("lit_err_count", 32'(bus.err_count), 32'(CHK_EN));
    @(posedge clk); #1;
    single(2'd3, 32'hFFF0_0000, 32'h0000_006F, 32'h8000_006F, 1'b0);
    single(2'd3, 32'h0010_0000, 32'h0000_006F, 32'h8000_006F, CHK_EN);

    // Backpressure: only two entries fit while out_ready is low.
    for (int i = 0; i < 4; i++) begin
      r_src[i] = 2'(i); r_imm[i] = 32'(i * 20 - 24); r_base[i] = 32'h0000_1000 * (i + 1) + 32'h33;
    end
    start = out_count;
    mode = 0;
    stream(4, 6);
    for (int t = 0; t < 60 && out_count - start < 4; t++) @(negedge clk);
    chk("bp_outputs", 32'(out_count - start), 32'd4);
    @(posedge clk); #1;

    // Reset with both stages full.
    r_src[0] = 2'd2; r_imm[0] = 32'h0000_0FFF; r_base[0] = 32'h0000_0063;
    r_src[1] = 2'd0; r_imm[1] = 32'h0000_0005; r_base[1] = 32'h0000_0013;
    mode = 0;
    stream(2, 0);
    reset = 1'b1;
    @(negedge clk); chk("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    @(posedge clk); #1; reset = 1'b0; mode = 1;
    @(negedge clk);
    chk("post_rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("post_rst_err_count", 32'(bus.err_count), 32'd0);
    chk("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;
    single(2'd0, 32'h0000_07FF, 32'h0000_0013, 32'h7FF0_0013, 1'b0);

    mode = 2;
    for (int n = 0; n < 400; n++) begin
      s = 2'($urandom);
      repeat ($urandom_range(2)) begin @(posedge clk); #1; end
      send(s, rand_imm(s), $urandom);
    end
    mode = 1;
    wait_drain();
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.ImmSrc = '0; bus.Imm = '0; bus.BaseInstr = '0;
    fork
      forever monitor_step();
      run_all();
      begin #1_000_000; chk("watchdog_timeout", 32'd0, 32'd1); end
    join_any
    disable fork;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/imm_encoder.md
IMM_ENCODER -- requirements
Module: imm_encoder

Interface
REQ-001 Parameter ERR_CNT_W, default 16, width of the saturating error counter.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  upstream request valid.
REQ-005 in_ready  output  1  block can accept a request this cycle.
REQ-006 ImmSrc  input  2  format: 00 I, 01 S, 10 B, 11 J.
REQ-007 Imm  input  32  signed byte-offset or immediate to encode.
REQ-008 BaseInstr  input  32  instruction carrying the non-immediate fields (opcode, rd, funct3, rs1, rs2, funct7).
REQ-009 out_valid  output  1  encoded instruction valid.
REQ-010 out_ready  input  1  downstream accepts this cycle.
REQ-011 Instr  output  32  encoded instruction.
REQ-012 out_err  output  1  Imm not representable in the selected format; qualifies Instr.
REQ-013 err_count  output  ERR_CNT_W  count of errored instructions delivered.

Function
REQ-014 Transfer occurs on an input when in_valid && in_ready, and on an output when out_valid && out_ready.
REQ-015 Two-register pipeline: S1 captures the request and computes the range check; S2 holds merged Instr/out_err driving the outputs.
REQ-016 Latency is 2 cycles from input transfer to out_valid with out_ready held high; throughput is 1 per cycle.
REQ-017 S2 loads when empty or when its current entry transfers out in the same cycle; S1 advances to S2 under the same condition.
REQ-018 in_ready = !S1_valid || S1 advancing; in_ready has no combinational dependence on in_valid.
REQ-019 Output holds Instr, out_err and out_valid stable while out_valid && !out_ready.
REQ-020 Instr bits outside the immediate field equal BaseInstr bits.
REQ-021 I: Instr[31:20] = Imm[11:0].
REQ-022 S: Instr[31:25] = Imm[11:5], Instr[11:7] = Imm[4:0].
REQ-023 B: Instr[31] = Imm[12], Instr[30:25] = Imm[10:5], Instr[11:8] = Imm[4:1], Instr[7] = Imm[11].
REQ-024 J: Instr[31] = Imm[20], Instr[30:21] = Imm[10:1], Instr[20] = Imm[11], Instr[19:12] = Imm[19:12].
REQ-025 Range rules: I/S require Imm[31:11] all equal; B requires Imm[31:12] all equal and Imm[0]=0; J requires Imm[31:20] all equal and Imm[0]=0.
REQ-026 Out-of-range immediates are still encoded from the truncated bits per REQ-021..024.
REQ-027 Round trip: for any in-range request, sign-extending Instr per ImmSrc (the core's immediate extension) yields Imm exactly.
REQ-028 err_count increments by 1 on each output transfer with out_err=1 and saturates at all-ones.
REQ-029 Simultaneous input transfer and output transfer with both stages full must not drop or duplicate an entry.

Reset
REQ-030 While reset is high: S1_valid=0, S2_valid=0, out_valid=0, Instr=0, out_err=0, err_count=0; in_ready=1 in the cycle after reset deasserts.
REQ-031 Reset asserted mid-operation discards all in-flight entries; no output transfer completes in a cycle with reset high.

Configuration
REQ-032 Macro IMM_RANGE_CHECK_EN defined: range checking, out_err and err_count operate per REQ-025/028.
REQ-033 Macro IMM_RANGE_CHECK_EN undefined: no check logic; out_err and err_count are tied to 0; encoding and handshake are unchanged.

Verification
REQ-034 I-type: BaseInstr=0x00000013, Imm=0xFFFFFFFF, out_ready=1 -> two cycles later Instr=0xFFF00013, out_err=0.
REQ-035 B-type: BaseInstr=0x00000063, Imm=0x00000FFE -> Instr=0x7E000FE3, out_err=0; Imm=0x00000FFF -> out_err=1, err_count=1.
REQ-036 J-type: BaseInstr=0x0000006F, Imm=0xFFF00000 -> Instr=0x8000006F, out_err=0; Imm=0x00100000 -> out_err=1.
REQ-037 Backpressure: stream 4 requests with out_ready=0 -> in_ready drops after 2 accepted, outputs stable; release out_ready -> 4 outputs in order, none lost.
REQ-038 Assert reset with both stages full -> out_valid=0 and err_count=0 next cycle; a fresh request then completes with 2-cycle latency.
REQ-039 Macro undefined: repeat REQ-035 -> out_err=0 and err_count=0 while Instr is unchanged.
